// File: rtl/control_turnos.sv
// control_turnos -- battleship turn sequencer.
//
// Runs the game flow between side 0 (human) and side 1 (PC): accepts a shot
// from the side whose turn it is, runs the board-lookup handshake, pulses the
// defender's lost-ship register enable on a hit and checks that register's
// status vector for end of game.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   start               start a new game (IDLE/OVER only)
//   shot_valid/x/y      shot from the active side; shot_ready high in WAIT_SHOT
//   lookup_req/side/x/y board lookup request, held until lookup_done
//   lookup_done/hit     lookup result, valid together
//   reg_enable[1:0]     one-cycle enable to the defender's lost-ship register
//   lost_p0/lost_p1     ship status vectors (1 = still afloat)
//   clear_boards        one-cycle pulse on game start
//   turn                side currently shooting
//   hit/miss/timeout_pulse  one-cycle event flags
//   game_over, winner   end-of-game status
module control_turnos #(
  parameter int NUM_BARCOS     = 5,
  parameter int COORD_W        = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  shot_valid,
  input  logic [COORD_W-1:0]    shot_x,
  input  logic [COORD_W-1:0]    shot_y,
  output logic                  shot_ready,
  output logic                  lookup_req,
  output logic                  lookup_side,
  output logic [COORD_W-1:0]    lookup_x,
  output logic [COORD_W-1:0]    lookup_y,
  input  logic                  lookup_done,
  input  logic                  lookup_hit,
  output logic [1:0]            reg_enable,
  input  logic [NUM_BARCOS-1:0] lost_p0,
  input  logic [NUM_BARCOS-1:0] lost_p1,
  output logic                  clear_boards,
  output logic                  turn,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic                  timeout_pulse,
  output logic                  game_over,
  output logic                  winner
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SHOT,
    S_LOOKUP,
    S_UPDATE,
    S_CHECK,
    S_SWITCH,
    S_OVER
  } state_t;

  state_t               r_state;
  logic                 r_turn;
  logic                 r_winner;
  logic [TW-1:0]        r_timer;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic                 r_side;
  logic                 r_clear;
  logic                 r_hit;
  logic                 r_miss;
  logic                 r_timeout;
  logic [NUM_BARCOS-1:0] w_def_vec;

  // Defender's status vector: the side not currently shooting.
  assign w_def_vec = r_turn ? lost_p0 : lost_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_turn    <= 1'b0;
      r_winner  <= 1'b0;
      r_timer   <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_side    <= 1'b0;
      r_clear   <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_clear   <= 1'b0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (start) begin
            r_clear <= 1'b1;
            r_turn  <= 1'b0;
            r_timer <= '0;
            r_state <= S_WAIT_SHOT;
          end
        end
        S_WAIT_SHOT: begin
          // A shot in the expiry cycle takes priority over the timeout.
          if (shot_valid) begin
            r_x     <= shot_x;
            r_y     <= shot_y;
            r_side  <= ~r_turn;
            r_state <= S_LOOKUP;
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_SWITCH;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_LOOKUP: begin
          if (lookup_done) begin
            if (lookup_hit) begin
              r_hit   <= 1'b1;
              r_state <= S_UPDATE;
            end else begin
              r_miss  <= 1'b1;
              r_state <= S_SWITCH;
            end
          end
        end
        S_UPDATE: r_state <= S_CHECK;
        S_CHECK: begin
          if (w_def_vec == '0) begin
            r_winner <= r_turn;
            r_state  <= S_OVER;
          end else begin
            r_timer <= '0;
            r_state <= S_WAIT_SHOT;
          end
        end
        S_SWITCH: begin
          r_turn  <= ~r_turn;
          r_timer <= '0;
          r_state <= S_WAIT_SHOT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Level outputs decode the state register directly so they follow the
  // asynchronous reset without waiting for a clock edge.
  assign shot_ready    = (r_state == S_WAIT_SHOT);
  assign lookup_req    = (r_state == S_LOOKUP);
  assign game_over     = (r_state == S_OVER);
  assign reg_enable    = (r_state == S_UPDATE) ? (r_turn ? 2'b01 : 2'b10) : 2'b00;
  assign lookup_side   = r_side;
  assign lookup_x      = r_x;
  assign lookup_y      = r_y;
  assign clear_boards  = r_clear;
  assign turn          = r_turn;
  assign hit_pulse     = r_hit;
  assign miss_pulse    = r_miss;
  assign timeout_pulse = r_timeout;
  assign winner        = r_winner;

endmodule

// File: tb/tb_control_turnos.sv
module tb_control_turnos;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       shot_valid;
  logic [2:0] shot_x, shot_y;
  logic       shot_ready;
  logic       lookup_req;
  logic       lookup_side;
  logic [2:0] lookup_x, lookup_y;
  logic       lookup_done;
  logic       lookup_hit;
  logic [1:0] reg_enable;
  logic [4:0] lost_p0, lost_p1;
  logic       clear_boards;
  logic       turn;
  logic       hit_pulse, miss_pulse, timeout_pulse;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_turnos #(
    .NUM_BARCOS    (5),
    .COORD_W       (3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .shot_valid   (shot_valid),
    .shot_x       (shot_x),
    .shot_y       (shot_y),
    .shot_ready   (shot_ready),
    .lookup_req   (lookup_req),
    .lookup_side  (lookup_side),
    .lookup_x     (lookup_x),
    .lookup_y     (lookup_y),
    .lookup_done  (lookup_done),
    .lookup_hit   (lookup_hit),
    .reg_enable   (reg_enable),
    .lost_p0      (lost_p0),
    .lost_p1      (lost_p1),
    .clear_boards (clear_boards),
    .turn         (turn),
    .hit_pulse    (hit_pulse),
    .miss_pulse   (miss_pulse),
    .timeout_pulse(timeout_pulse),
    .game_over    (game_over),
    .winner       (winner)
  );

  // Output bundle: {shot_ready, lookup_req, lookup_side, lookup_x, lookup_y,
  //                 reg_enable, clear_boards, turn, hit, miss, timeout,
  //                 game_over, winner}
  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic       sv;
    logic [2:0] x;
    logic [2:0] y;
    logic       done;
    logic       hit;
    logic [4:0] p0;
    logic [4:0] p1;
    logic [17:0] exp;
  } vec_t;

  vec_t vecs[$];

  localparam logic [4:0] F   = 5'b11111;
  localparam logic [4:0] P1H = 5'b10110;

  function automatic logic [17:0] ex(input logic sr, input logic req,
                                     input logic side, input logic [2:0] lx,
                                     input logic [2:0] ly, input logic [1:0] en,
                                     input logic clr, input logic trn,
                                     input logic h, input logic m, input logic t,
                                     input logic go, input logic w);
    return {sr, req, side, lx, ly, en, clr, trn, h, m, t, go, w};
  endfunction

  function automatic logic [17:0] outs();
    return {shot_ready, lookup_req, lookup_side, lookup_x, lookup_y, reg_enable,
            clear_boards, turn, hit_pulse, miss_pulse, timeout_pulse, game_over,
            winner};
  endfunction

  task automatic add(input string nm, input logic r, input logic st,
                     input logic sv, input logic [2:0] x, input logic [2:0] y,
                     input logic d, input logic h, input logic [4:0] p0,
                     input logic [4:0] p1, input logic [17:0] e);
    vec_t v;
    v.name = nm; v.rst_n = r; v.start = st; v.sv = sv; v.x = x; v.y = y;
    v.done = d; v.hit = h; v.p0 = p0; v.p1 = p1; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [17:0] act,
                     input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic sv,
                       input logic [2:0] x, input logic [2:0] y,
                       input logic d, input logic h);
    rst = r; start = st; shot_valid = sv; shot_x = x; shot_y = y;
    lookup_done = d; lookup_hit = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    lost_p0 = F;
    lost_p1 = F;

    // Reset, start, side 0 misses at (2,3)
    add("reset",     0, 0, 0, 0, 0, 0, 0, F, F, ex(0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    add("idle",      1, 0, 0, 0, 0, 0, 0, F, F, ex(0,0,0,0,0,2'b00,0,0,0,0,0,0,0));
    add("start",     1, 1, 0, 0, 0, 0, 0, F, F, ex(1,0,0,0,0,2'b00,1,0,0,0,0,0,0));
    add("shot0",     1, 0, 1, 2, 3, 0, 0, F, F, ex(0,1,1,2,3,2'b00,0,0,0,0,0,0,0));
    add("lk_wait",   1, 0, 0, 0, 0, 0, 0, F, F, ex(0,1,1,2,3,2'b00,0,0,0,0,0,0,0));
    add("miss",      1, 0, 0, 0, 0, 1, 0, F, F, ex(0,0,1,2,3,2'b00,0,0,0,1,0,0,0));
    add("ready_2cy", 1, 0, 0, 0, 0, 0, 0, F, F, ex(1,0,1,2,3,2'b00,0,1,0,0,0,0,0));
    // Stray lookup_done and start in WAIT_SHOT are ignored
    add("done_ign",  1, 1, 0, 0, 0, 1, 1, F, F, ex(1,0,1,2,3,2'b00,0,1,0,0,0,0,0));
    // Side 1 never shoots: 16 WAIT_SHOT cycles then timeout
    for (int i = 0; i < 14; i++)
      add("to_wait", 1, 0, 0, 0, 0, 0, 0, F, F, ex(1,0,1,2,3,2'b00,0,1,0,0,0,0,0));
    add("timeout",   1, 0, 0, 0, 0, 0, 0, F, F, ex(0,0,1,2,3,2'b00,0,1,0,0,1,0,0));
    add("after_to",  1, 0, 0, 0, 0, 0, 0, F, F, ex(1,0,1,2,3,2'b00,0,0,0,0,0,0,0));
    // Side 0 hits at (5,1); defender register becomes 10110, turn kept
    add("shot_hit",  1, 0, 1, 5, 1, 0, 0, F, F,   ex(0,1,1,5,1,2'b00,0,0,0,0,0,0,0));
    add("hit",       1, 0, 0, 0, 0, 1, 1, F, F,   ex(0,0,1,5,1,2'b10,0,0,1,0,0,0,0));
    add("update",    1, 0, 0, 0, 0, 0, 0, F, P1H, ex(0,0,1,5,1,2'b00,0,0,0,0,0,0,0));
    add("check",     1, 0, 0, 0, 0, 0, 0, F, P1H, ex(1,0,1,5,1,2'b00,0,0,0,0,0,0,0));
    // Timeout tie: shot arrives in the 16th WAIT_SHOT cycle
    for (int i = 0; i < 15; i++)
      add("tie_wait", 1, 0, 0, 0, 0, 0, 0, F, P1H, ex(1,0,1,5,1,2'b00,0,0,0,0,0,0,0));
    add("tie_shot",  1, 0, 1, 1, 6, 0, 0, F, P1H, ex(0,1,1,1,6,2'b00,0,0,0,0,0,0,0));
    add("tie_miss",  1, 0, 0, 0, 0, 1, 0, F, P1H, ex(0,0,1,1,6,2'b00,0,0,0,1,0,0,0));
    add("turn1",     1, 0, 0, 0, 0, 0, 0, F, P1H, ex(1,0,1,1,6,2'b00,0,1,0,0,0,0,0));
    // Side 1 sinks the last ship of side 0
    add("shot_go",   1, 0, 1, 0, 7, 0, 0, F, F,   ex(0,1,0,0,7,2'b00,0,1,0,0,0,0,0));
    add("hit_go",    1, 0, 0, 0, 0, 1, 1, F, F,   ex(0,0,0,0,7,2'b01,0,1,1,0,0,0,0));
    add("upd_go",    1, 0, 0, 0, 0, 0, 0, 0, F,   ex(0,0,0,0,7,2'b00,0,1,0,0,0,0,0));
    add("over",      1, 0, 0, 0, 0, 0, 0, 0, F,   ex(0,0,0,0,7,2'b00,0,1,0,0,0,1,1));
    add("over_ign",  1, 0, 1, 3, 3, 1, 1, 0, F,   ex(0,0,0,0,7,2'b00,0,1,0,0,0,1,1));
    add("restart",   1, 1, 0, 0, 0, 0, 0, 0, F,   ex(1,0,0,0,7,2'b00,1,0,0,0,0,0,1));
    add("new_game",  1, 0, 0, 0, 0, 0, 0, F, F,   ex(1,0,0,0,7,2'b00,0,0,0,0,0,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].start, vecs[i].sv, vecs[i].x, vecs[i].y,
            vecs[i].done, vecs[i].hit);
      lost_p0 = vecs[i].p0;
      lost_p1 = vecs[i].p1;
      step();
      chk($sformatf("%s[%0d]", vecs[i].name, i), outs(), vecs[i].exp);
    end

    // Reset in the middle of a side-1 lookup
    lost_p0 = F;
    lost_p1 = F;
    drive(1, 0, 1, 2, 2, 0, 0); step();
    chk("mid_lk_req0", {17'b0, lookup_req}, 18'd1);
    drive(1, 0, 0, 0, 0, 1, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0); step();
    chk("mid_turn1", {17'b0, turn}, 18'd1);
    drive(1, 0, 1, 4, 4, 0, 0); step();
    chk("mid_lk_req1", {16'b0, lookup_req, lookup_side}, 18'b10);
    #2;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("async_rst", {12'b0, lookup_req, turn, game_over, shot_ready, winner, clear_boards},
        18'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_idle%0d", i), {17'b0, shot_ready}, 18'd0);
    end
    drive(1, 1, 0, 0, 0, 0, 0); step();
    chk("post_rst_start", {16'b0, shot_ready, clear_boards}, 18'b11);
    drive(1, 0, 0, 0, 0, 0, 0); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
